// File: rtl/vc_rr_arb_index_pkg.sv
// Shared arbiter definitions (vcArbDefs): index-width helper and pointer reset value.
// Consumed by the arbiter interface, the pick sub-module and the top level.
package vc_rr_arb_index_pkg;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Pointer resets to the highest index so index 0 is scanned first.
  function automatic int last_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/vc_rr_arb_index_if.sv
// Request/grant bundle between requesters, the arbiter (master) and the grant consumer (slave).
// grant_onehot exists only when VC_RR_ARB_INDEX_ONEHOT_EN is defined.
interface vc_rr_arb_index_if
  import vc_rr_arb_index_pkg::*;
#(
  parameter int NUM_REQS = 8,
  parameter int W_IDX    = idx_width(NUM_REQS)
);
  logic [NUM_REQS-1:0] req_bits;
  logic                grant_val;
  logic                grant_rdy;
  logic [W_IDX-1:0]    grant_idx;
`ifdef VC_RR_ARB_INDEX_ONEHOT_EN
  logic [NUM_REQS-1:0] grant_onehot;

  modport master (input req_bits, input grant_rdy,
                  output grant_val, output grant_idx, output grant_onehot);
  modport slave  (output req_bits, output grant_rdy,
                  input grant_val, input grant_idx, input grant_onehot);
`else
  modport master (input req_bits, input grant_rdy,
                  output grant_val, output grant_idx);
  modport slave  (output req_bits, output grant_rdy,
                  input grant_val, input grant_idx);
`endif
endinterface

// File: rtl/vc_rr_arb_index_pick.sv
// Combinational round-robin search: first set bit of eligible scanning last+1, last+2, ...
// with wrap, last itself checked last.
module vc_rr_arb_pick
  import vc_rr_arb_index_pkg::*;
#(
  parameter int NUM_REQS = 8,
  parameter int W_IDX    = idx_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] eligible,
  input  logic [W_IDX-1:0]    last,
  output logic [W_IDX-1:0]    pick,
  output logic                found
);
  localparam int WS = W_IDX + 2;

  logic [2*NUM_REQS-1:0] dbl_s;
  logic [NUM_REQS-1:0]   rot_s;
  logic [W_IDX-1:0]      off_s;
  logic [WS-1:0]         sum_s;

  // Rotate so bit 0 is index last+1, find the lowest set bit, then map back modulo NUM_REQS.
  always_comb begin
    dbl_s = {eligible, eligible} >> ({1'b0, last} + {{W_IDX{1'b0}}, 1'b1});
    rot_s = dbl_s[NUM_REQS-1:0];
    off_s = '0;
    for (int j = NUM_REQS - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? W_IDX'(j) : off_s;
    end
    found = |rot_s;
    sum_s = WS'(last) + WS'(off_s) + WS'(1);
    pick  = (sum_s >= WS'(NUM_REQS)) ? W_IDX'(sum_s - WS'(NUM_REQS)) : W_IDX'(sum_s);
  end

endmodule

// File: rtl/vc_rr_arb_index.sv
// Round-robin arbiter emitting a registered binary grant index on a val/rdy port.
// Optional feature macro: VC_RR_ARB_INDEX_ONEHOT_EN adds a registered one-hot grant output.
module vc_rr_arb_index
  import vc_rr_arb_index_pkg::*;
#(
  parameter int NUM_REQS = 8,
  parameter int W_IDX    = idx_width(NUM_REQS)
) (
  input  logic               clk,
  input  logic               reset,
  vc_rr_arb_index_if.master  arb
);
  localparam logic [W_IDX-1:0] LAST_RST = W_IDX'(last_reset(NUM_REQS));

  logic                val_r;
  logic [W_IDX-1:0]    idx_r;
  logic [W_IDX-1:0]    last_r;
  logic                fire_s;
  logic                load_s;
  logic [NUM_REQS-1:0] mask_s;
  logic [NUM_REQS-1:0] eligible_s;
  logic [W_IDX-1:0]    pick_s;
  logic                found_s;

  assign fire_s = val_r & arb.grant_rdy;
  assign load_s = ~val_r | arb.grant_rdy;
  // The requester being acknowledged this cycle still shows its request; keep it out of the race.
  assign mask_s     = fire_s ? (NUM_REQS'(1) << idx_r) : '0;
  assign eligible_s = arb.req_bits & ~mask_s;

  vc_rr_arb_pick #(
    .NUM_REQS (NUM_REQS),
    .W_IDX    (W_IDX)
  ) u_pick (
    .eligible (eligible_s),
    .last     (last_r),
    .pick     (pick_s),
    .found    (found_s)
  );

  // Output register and priority pointer; everything holds while a grant stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_r  <= 1'b0;
      idx_r  <= '0;
      last_r <= LAST_RST;
    end else if (load_s) begin
      if (found_s) begin
        val_r  <= 1'b1;
        idx_r  <= pick_s;
        last_r <= pick_s;
      end else begin
        val_r  <= 1'b0;
      end
    end else begin
      val_r  <= val_r;
    end
  end

  assign arb.grant_val = val_r;
  assign arb.grant_idx = idx_r;

`ifdef VC_RR_ARB_INDEX_ONEHOT_EN
  logic [NUM_REQS-1:0] onehot_r;

  // One-hot copy of the grant, loaded in the same stage as idx_r and cleared when no grant is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      onehot_r <= '0;
    end else if (load_s) begin
      if (found_s) begin
        onehot_r <= NUM_REQS'(1) << pick_s;
      end else begin
        onehot_r <= '0;
      end
    end else begin
      onehot_r <= onehot_r;
    end
  end

  assign arb.grant_onehot = onehot_r;
`endif

endmodule

// File: tb/tb_vc_rr_arb_index.sv
// Randomized and directed bench for vc_rr_arb_index against a scan-based reference model.
module tb_vc_rr_arb_index;
  localparam int N = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_val;
  int m_idx;
  int m_last;

  vc_rr_arb_index_if #(.NUM_REQS(N), .W_IDX(W)) bus ();

  vc_rr_arb_index #(.NUM_REQS(N), .W_IDX(W)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: apply the arbitration rules for one clock edge.
  task automatic model_edge(input logic [N-1:0] req, input logic rdy, input logic rst);
    int  fire;
    int  found;
    int  pick;
    int  c;
    if (rst) begin
      m_val  = 0;
      m_idx  = 0;
      m_last = N - 1;
    end else begin
      fire = (m_val == 1 && rdy) ? 1 : 0;
      if (m_val == 0 || rdy) begin
        found = 0;
        pick  = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (found == 0 && req[c] && !(fire == 1 && c == m_idx)) begin
            found = 1;
            pick  = c;
          end
        end
        if (found == 1) begin
          m_val  = 1;
          m_idx  = pick;
          m_last = pick;
        end else begin
          m_val = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic rdy, input logic rst);
    bus.req_bits  = req;
    bus.grant_rdy = rdy;
    reset         = rst;
    model_edge(req, rdy, rst);
    @(posedge clk);
    #1;
    check_eq("grant_val", 32'(bus.grant_val), 32'(m_val));
    check_eq("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
`ifdef VC_RR_ARB_INDEX_ONEHOT_EN
    check_eq("grant_onehot", 32'(bus.grant_onehot), (m_val == 1) ? (32'(1) << m_idx) : 32'(0));
`endif
  endtask

  initial begin
    logic [N-1:0] r;
    logic         rd;
    logic         rs;
    m_val = 0; m_idx = 0; m_last = N - 1;
    bus.req_bits = '0; bus.grant_rdy = 1'b0; reset = 1'b1;

    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    check_eq("reset_val", 32'(bus.grant_val), 32'(0));
    check_eq("reset_idx", 32'(bus.grant_idx), 32'(0));

    // Sole requester alternates granted / masked.
    step(8'h01, 1'b1, 1'b0);
    check_eq("solo_grant", {31'(0), bus.grant_val}, 32'(1));
    step(8'h01, 1'b1, 1'b0);
    check_eq("solo_masked", {31'(0), bus.grant_val}, 32'(0));
    step(8'h01, 1'b1, 1'b0);
    check_eq("solo_again", 32'(bus.grant_idx), 32'(0));

    // All requesters: indices rotate one per cycle.
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      check_eq("rotate_idx", 32'(bus.grant_idx), 32'(i % N));
    end

    // Stall holds idx 4, then fire moves to 7, then wrap to 0 and back to 7.
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(8'h90, 1'b0, 1'b0);
      check_eq("stall_idx", 32'(bus.grant_idx), 32'(4));
    end
    step(8'h90, 1'b1, 1'b0);
    check_eq("after_stall", 32'(bus.grant_idx), 32'(7));
    step(8'h81, 1'b1, 1'b0);
    check_eq("wrap_to_0", 32'(bus.grant_idx), 32'(0));
    step(8'h81, 1'b1, 1'b0);
    check_eq("wrap_to_7", 32'(bus.grant_idx), 32'(7));

    // Reset during a stall on idx 5 drops the grant; priority restarts at 0.
    step(8'h20, 1'b1, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    check_eq("stall5_idx", 32'(bus.grant_idx), 32'(5));
    step(8'hFF, 1'b0, 1'b1);
    check_eq("rst_stall_val", 32'(bus.grant_val), 32'(0));
    step(8'hFF, 1'b1, 1'b0);
    check_eq("post_rst_idx", 32'(bus.grant_idx), 32'(0));

`ifdef VC_RR_ARB_INDEX_ONEHOT_EN
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    check_eq("onehot_3", 32'(bus.grant_onehot), 32'(8'b0000_1000));
    step(8'h00, 1'b1, 1'b0);
    check_eq("onehot_idle", 32'(bus.grant_onehot), 32'(0));
`endif

    // Random traffic against the model, including rdy without val and occasional reset.
    for (int i = 0; i < 400; i++) begin
      r  = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      rd = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 60) == 0);
      step(r, rd, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_rr_arb_index.md
# vc_rr_arb_index

Round-robin arbiter that picks one of `NUM_REQS` level-sensitive requesters and emits the winner as a registered binary index on a val/rdy output port. It sits directly upstream of the library's binary-to-one-hot decoder. Downstream logic decodes `grant_idx` to steer a mux and to acknowledge the granted requester when the output fires.

## Interface
- `NUM_REQS`, default 8: number of requesters; must be ≥2.
- `W_IDX`, default 3: index width; must satisfy 2^`W_IDX` ≥ `NUM_REQS`.
- `clk` in, 1: sole clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `req_bits` in, `NUM_REQS`: bit i high means requester i has work; held until acknowledged.
- `grant_val` out, 1: `grant_idx` holds a valid winner.
- `grant_rdy` in, 1: consumer accepts the grant this cycle.
- `grant_idx` out, `W_IDX`: binary index of the granted requester.
- `grant_onehot` out, `NUM_REQS`: present only with `VC_RR_ARB_INDEX_ONEHOT_EN`.

## Operation
- State:
  - output register (`grant_val`, `grant_idx`);
  - priority pointer `last`, `W_IDX` bits, holding the most recent captured index.
- Fire is defined as `grant_val & grant_rdy`.
- Load is enabled when `!grant_val | grant_rdy` (register empty or draining).
- Eligible set is `req_bits` with the following mask:
  - on a fire cycle, bit `grant_idx` is cleared, so the just-acknowledged requester cannot be re-captured before it updates `req_bits`;
  - bits at or above `NUM_REQS` never exist.
- Pick rule: first eligible index scanning `last+1, last+2, …` with wrap from `NUM_REQS-1` to 0; `last` itself is checked last.
- Load enabled and eligible set non-empty:
  - `grant_idx` ← pick;
  - `grant_val` ← 1;
  - `last` ← pick.
- Load enabled and eligible set empty: `grant_val` ← 0; `grant_idx` and `last` are unchanged.
- Load disabled (stall): all state is held, and `grant_idx` must stay stable while `grant_val & !grant_rdy`.
- A requester dropping `req_bits` while already granted does not revoke the grant. The grant stays until it fires.
- A sole continuously-requesting agent is granted every other cycle, because of the fire-cycle mask. This is intended.

## Timing
- Reset values:
  - `grant_val`=0;
  - `grant_idx`=0;
  - `last`=`NUM_REQS-1`, so index 0 has first priority;
  - `grant_onehot`=0.
- Latency: request visible at edge N gives `grant_val` high after edge N (1 cycle), provided load was enabled.
- Back-to-back fires are allowed, one per cycle, when two or more requesters are active.
- Reset asserted mid-stall discards the pending grant; the first cycle after reset shows `grant_val`=0.
- `grant_rdy` may be high while `grant_val` is low; this has no effect.
- No combinational path from `req_bits` or `grant_rdy` to any output.

## Configuration
- `VC_RR_ARB_INDEX_ONEHOT_EN` defined:
  - adds output `grant_onehot`, registered in the same flop stage;
  - equals the one-hot decode of `grant_idx` when `grant_val`=1, else all zeros.
- Undefined: port and flops are absent; the index-only behaviour is unchanged.

## Structure
- Shared library include (`vcArbDefs`):
  - index-width helper constant/function (ceil-log2) used to size `W_IDX`;
  - reset value for `last`.
- One natural sub-module, `vc_rr_arb_pick`:
  - purely combinational rotate-and-priority-search;
  - inputs: eligible vector and `last`;
  - outputs: pick index and a found flag.
- The top level holds the output register, pointer, fire mask and the optional one-hot register.

## Test plan
- Post-reset, `req_bits`=8'b0000_0001, `grant_rdy`=1: `grant_val`=1 with `grant_idx`=0 one cycle later. Next cycle `grant_val`=0 (masked). Then idx=0 again, alternating.
- All-ones `req_bits`, `grant_rdy`=1 for 10 cycles: `grant_idx` sequence 0,1,2,…,7,0,1, one per cycle.
- `req_bits`=8'b1001_0000, `grant_rdy`=0 for 5 cycles: `grant_idx`=4 held stable with `grant_val`=1. On raising `grant_rdy`: fire on idx 4, next grant idx 7.
- Wrap: after a grant at idx 7, `req_bits`=8'b1000_0001 gives idx 0, then idx 7.
- Reset asserted during a stall holding idx 5: `grant_val`=0 next cycle. With all requests active, the first grant afterwards is idx 0.
- With `VC_RR_ARB_INDEX_ONEHOT_EN`: `grant_idx`=3 and `grant_val`=1 give `grant_onehot`=8'b0000_1000. With `grant_val`=0, `grant_onehot`=8'b0.
